regex_instruction_cache: RTL and testbench

//  Direct-mapped, one-word-per-line instruction cache between regex_cpu_pipelined's memory port
//  (memory_valid/addr/ready/data) and the shared instruction memory bus.

---
 rtl/regex_instruction_cache.sv | 183 ++++++++++++++++++
 tb/tb_regex_instruction_cache.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regex_instruction_cache.sv
//------------------------------------------------------------------------------
// Module      : regex_instruction_cache
// Description : Direct-mapped, one-word-per-line instruction cache that sits
//               between a regex CPU fetch port and a shared instruction memory
//               bus. One outstanding miss; invalidate flushes all lines.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regex_instruction_cache #(
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int CACHE_LINES_POW2  = 4,
    parameter int COUNTER_WIDTH     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    // CPU fetch port
    input  logic                         cpu_valid,
    input  logic [MEMORY_ADDR_WIDTH-1:0] cpu_addr,
    output logic                         cpu_ready,
    output logic [MEMORY_WIDTH-1:0]      cpu_data,
    // Memory bus port
    output logic                         mem_req_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                         mem_req_ready,
    input  logic                         mem_rsp_valid,
    input  logic [MEMORY_WIDTH-1:0]      mem_rsp_data,
    // Control and status
    input  logic                         invalidate,
    output logic                         busy,
    output logic [COUNTER_WIDTH-1:0]     hit_count,
    output logic [COUNTER_WIDTH-1:0]     miss_count
);

    localparam int LINES     = 1 << CACHE_LINES_POW2;
    localparam int TAG_WIDTH = MEMORY_ADDR_WIDTH - CACHE_LINES_POW2;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HIT_RESP  = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        FILL_RESP = 3'd4
    } state_t;

    state_t                         state;

    // Line storage: valid bits are reset, tag/data are only meaningful when valid
    logic [LINES-1:0]               line_valid;
    logic [TAG_WIDTH-1:0]           tag_mem  [LINES];
    logic [MEMORY_WIDTH-1:0]        data_mem [LINES];

    // Address of the access in flight, independent of later cpu_addr changes
    logic [MEMORY_ADDR_WIDTH-1:0]   addr_q;
    // Set when an invalidate lands while a miss is outstanding; suppresses the fill
    logic                           inv_pending;

    logic [CACHE_LINES_POW2-1:0]    lookup_idx;
    logic [TAG_WIDTH-1:0]           lookup_tag;
    logic                           lookup_hit;
    logic [CACHE_LINES_POW2-1:0]    fill_idx;
    logic [TAG_WIDTH-1:0]           fill_tag;
    logic                           fill_we;

    assign lookup_idx = cpu_addr[CACHE_LINES_POW2-1:0];
    assign lookup_tag = cpu_addr[MEMORY_ADDR_WIDTH-1:CACHE_LINES_POW2];
    // A simultaneous invalidate makes every line look empty to this lookup
    assign lookup_hit = line_valid[lookup_idx] &&
                        (tag_mem[lookup_idx] == lookup_tag) &&
                        !invalidate;

    assign fill_idx = addr_q[CACHE_LINES_POW2-1:0];
    assign fill_tag = addr_q[MEMORY_ADDR_WIDTH-1:CACHE_LINES_POW2];
    // Invalidate (now or earlier in this miss) wins over the refill
    assign fill_we  = (state == MISS_WAIT) && mem_rsp_valid &&
                      !invalidate && !inv_pending;

    // Valid bits: flushed by reset or invalidate, set by a permitted refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid <= '0;
        end else if (invalidate) begin
            line_valid <= '0;
        end else if (fill_we) begin
            line_valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays written on refill; aliasing lines are simply overwritten
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_rsp_data;
        end
    end

    // Control FSM with registered CPU/bus outputs and saturating statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cpu_ready     <= 1'b0;
            cpu_data      <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            busy          <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
            addr_q        <= '0;
            inv_pending   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    inv_pending <= 1'b0;
                    if (cpu_valid) begin
                        addr_q <= cpu_addr;
                        busy   <= 1'b1;
                        if (lookup_hit) begin
                            cpu_ready <= 1'b1;
                            cpu_data  <= data_mem[lookup_idx];
                            state     <= HIT_RESP;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= cpu_addr;
                            state         <= MISS_REQ;
                        end
                    end
                end

                HIT_RESP: begin
                    cpu_ready <= 1'b0;
                    busy      <= 1'b0;
                    if (hit_count != CNT_MAX) begin
                        hit_count <= hit_count + CNT_ONE;
                    end
                    state <= IDLE;
                end

                MISS_REQ: begin
                    if (invalidate) begin
                        inv_pending <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= MISS_WAIT;
                    end
                end

                MISS_WAIT: begin
                    if (invalidate) begin
                        inv_pending <= 1'b1;
                    end
                    if (mem_rsp_valid) begin
                        cpu_ready <= 1'b1;
                        cpu_data  <= mem_rsp_data;
                        state     <= FILL_RESP;
                    end
                end

                FILL_RESP: begin
                    cpu_ready <= 1'b0;
                    busy      <= 1'b0;
                    if (miss_count != CNT_MAX) begin
                        miss_count <= miss_count + CNT_ONE;
                    end
                    state <= IDLE;
                end

                default: begin
                    cpu_ready     <= 1'b0;
                    mem_req_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regex_instruction_cache.sv
//------------------------------------------------------------------------------
// Module      : tb_regex_instruction_cache
// Description : Self-checking bench for regex_instruction_cache. Expected
//               fetch words are queued when a fetch is issued and compared
//               when the cache pulses cpu_ready.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regex_instruction_cache;

    logic        clk;
    logic        rst;
    logic        cpu_valid;
    logic [10:0] cpu_addr;
    logic        cpu_ready;
    logic [15:0] cpu_data;
    logic        mem_req_valid;
    logic [10:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_data;
    logic        invalidate;
    logic        busy;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sb_q[$];

    // Reference model of cache contents and statistics
    logic [15:0] mv;
    logic [6:0]  mt [16];
    int          exp_hits   = 0;
    int          exp_misses = 0;
    int          acc_cnt    = 0;

    regex_instruction_cache #(
        .MEMORY_WIDTH      (16),
        .MEMORY_ADDR_WIDTH (11),
        .CACHE_LINES_POW2  (4),
        .COUNTER_WIDTH     (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_valid     (cpu_valid),
        .cpu_addr      (cpu_addr),
        .cpu_ready     (cpu_ready),
        .cpu_data      (cpu_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .invalidate    (invalidate),
        .busy          (busy),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Backing memory contents
    function automatic logic [15:0] mem_word(input logic [10:0] a);
        if (a == 11'h06E) return 16'hA5A5;
        return {a[7:0] ^ 8'h5A, a[10:3]};
    endfunction

    // Scoreboard: every cpu_ready pulse must match the oldest queued word
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst && cpu_ready) begin
            if (sb_q.size() == 0) begin
                check_value("unexpected_ready", cpu_ready, 0);
            end else begin
                e = sb_q.pop_front();
                check_value("rsp_data", cpu_data, e);
            end
        end
    end

    // Count accepted bus requests
    always @(posedge clk) begin
        if (!rst && mem_req_valid && mem_req_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic fetch(input logic [10:0] a, input int ready_lat, input int rsp_lat,
                         input bit inv_idle, input bit inv_wait);
        logic [3:0]  idx;
        logic [6:0]  tg;
        logic [15:0] w;
        bit          hit;
        idx = a[3:0];
        tg  = a[10:4];
        w   = mem_word(a);
        hit = mv[idx] && (mt[idx] == tg) && !inv_idle;
        @(negedge clk);
        cpu_valid  = 1'b1;
        cpu_addr   = a;
        invalidate = inv_idle;
        sb_q.push_back(w);
        if (inv_idle) mv = '0;
        @(posedge clk); #1;
        invalidate = 1'b0;
        check_value("busy_active", busy, 1);
        if (hit) begin
            check_value("hit_ready", cpu_ready, 1);
            check_value("hit_no_req", mem_req_valid, 0);
            cpu_valid = 1'b0;
            cpu_addr  = ~a;
            exp_hits++;
        end else begin
            check_value("miss_req_valid", mem_req_valid, 1);
            check_value("miss_req_addr", mem_req_addr, a);
            check_value("miss_not_ready", cpu_ready, 0);
            cpu_addr = ~a;
            for (int i = 0; i < ready_lat; i++) begin
                mem_rsp_valid = (i == 0);
                mem_rsp_data  = 16'hDEAD;
                @(posedge clk); #1;
                mem_rsp_valid = 1'b0;
                check_value("req_hold_valid", mem_req_valid, 1);
                check_value("req_hold_addr", mem_req_addr, a);
                check_value("req_hold_noready", cpu_ready, 0);
            end
            mem_req_ready = 1'b1;
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            check_value("req_dropped", mem_req_valid, 0);
            for (int i = 0; i < rsp_lat; i++) begin
                invalidate = inv_wait && (i == 0);
                @(posedge clk); #1;
                invalidate = 1'b0;
                check_value("wait_no_ready", cpu_ready, 0);
            end
            if (inv_wait) mv = '0;
            else begin
                mv[idx] = 1'b1;
                mt[idx] = tg;
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = w;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 16'h0BAD;
            check_value("fill_ready", cpu_ready, 1);
            cpu_valid = 1'b0;
            exp_misses++;
        end
        @(posedge clk); #1;
        check_value("ready_pulse_end", cpu_ready, 0);
        check_value("idle_not_busy", busy, 0);
        check_value("hit_count", hit_count, exp_hits);
        check_value("miss_count", miss_count, exp_misses);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [10:0] pool [5];
        pool[0] = 11'h06E; pool[1] = 11'h07E; pool[2] = 11'h010;
        pool[3] = 11'h3A1; pool[4] = 11'h2B1;
        mv = '0;
        rst = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; invalidate = 1'b0;
        repeat (2) @(negedge clk);
        check_value("rst_cpu_ready", cpu_ready, 0);
        check_value("rst_cpu_data", cpu_data, 0);
        check_value("rst_req_valid", mem_req_valid, 0);
        check_value("rst_req_addr", mem_req_addr, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_hits", hit_count, 0);
        check_value("rst_misses", miss_count, 0);
        rst = 1'b0;

        // Cold miss, then hit
        fetch(11'h06E, 0, 3, 0, 0);
        fetch(11'h06E, 0, 0, 0, 0);
        // Aliasing eviction
        fetch(11'h07E, 0, 2, 0, 0);
        fetch(11'h06E, 0, 1, 0, 0);
        fetch(11'h06E, 0, 0, 0, 0);
        // Invalidate during MISS_WAIT: word delivered, line not written
        fetch(11'h010, 0, 2, 0, 1);
        fetch(11'h010, 0, 1, 0, 0);
        fetch(11'h010, 0, 0, 0, 0);
        // Back-pressure: one request only, stable address
        base = acc_cnt;
        fetch(11'h055, 5, 1, 0, 0);
        check_value("one_request", acc_cnt - base, 1);
        // Invalidate coincident with an IDLE lookup of a cached line
        fetch(11'h055, 0, 1, 1, 0);
        fetch(11'h055, 0, 0, 0, 0);
        // Mixed traffic
        for (int i = 0; i < 10; i++) begin
            fetch(pool[$urandom_range(0, 4)], $urandom_range(0, 2),
                  $urandom_range(1, 3), 0, (i == 4));
        end

        // Asynchronous reset while waiting for the response
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = 11'h123;
        @(posedge clk); #1;
        check_value("rstmiss_req", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        cpu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_value("arst_busy", busy, 0);
        check_value("arst_cpu_ready", cpu_ready, 0);
        check_value("arst_cpu_data", cpu_data, 0);
        check_value("arst_req_valid", mem_req_valid, 0);
        check_value("arst_req_addr", mem_req_addr, 0);
        check_value("arst_hits", hit_count, 0);
        check_value("arst_misses", miss_count, 0);
        mv = '0; exp_hits = 0; exp_misses = 0;
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 16'h7777;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_value("late_rsp_ignored", cpu_ready, 0);
            check_value("late_rsp_idle", busy, 0);
        end
        fetch(11'h123, 0, 1, 0, 0);
        fetch(11'h06E, 0, 1, 0, 0);
        fetch(11'h123, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        check_value("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
